// File: rtl/count_enable_debouncer.sv
// count_enable_debouncer
// Conditions a raw, bouncing, asynchronous button or sensor line for the
// T-flip-flop ripple counter chain. The line is synchronised to clk and then
// qualified by a stability counter and a four-state FSM. Each accepted
// transition that matches EDGE produces a clean one-cycle toggle-enable pulse.
//
// Parameters:
//   CW            width of the stability counter
//   STABLE_CYCLES cycles a new level must persist (1 .. 2**CW-1)
//   EDGE          0 = pulse on rising, 1 = pulse on falling, 2 = pulse on both
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   btn_in     raw asynchronous input, may bounce
//   en         pulse enable, sampled only at the acceptance edge
//   t          registered one-cycle toggle-enable pulse
//   btn_state  debounced level
//   busy       high while a candidate transition is being qualified
module count_enable_debouncer #(
    parameter int CW            = 16,
    parameter int STABLE_CYCLES = 50000,
    parameter int EDGE          = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    input  logic en,
    output logic t,
    output logic btn_state,
    output logic busy
);

    // Elaboration-time guard against an unusable configuration.
    generate
        if (STABLE_CYCLES < 1 || STABLE_CYCLES > (2 ** CW) - 1) begin : g_cfg_stable_err
            $error("count_enable_debouncer: STABLE_CYCLES out of range for CW");
        end
        if (EDGE < 0 || EDGE > 2) begin : g_cfg_edge_err
            $error("count_enable_debouncer: EDGE must be 0, 1 or 2");
        end
    endgenerate

    localparam logic [CW-1:0] LAST_CNT   = CW'(STABLE_CYCLES - 1);
    localparam logic          PULSE_RISE = (EDGE == 0) || (EDGE == 2);
    localparam logic          PULSE_FALL = (EDGE == 1) || (EDGE == 2);

    typedef enum logic [1:0] {
        IDLE_LOW,
        WAIT_HIGH,
        IDLE_HIGH,
        WAIT_LOW
    } state_t;

    // Two-flop synchroniser: stage 0 samples btn_in, each later stage samples
    // the one before. Only the last stage is used downstream.
    logic [1:0] sync_reg;
    logic       s2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_reg[gi] <= 1'b0;
                end else if (gi == 0) begin
                    sync_reg[gi] <= btn_in;
                end else begin
                    sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi - 1];
                end
            end
        end
    endgenerate

    assign s2 = sync_reg[1];

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          btn_state_reg, btn_state_next;
    logic          busy_reg, busy_next;
    logic          t_reg, t_next;
    logic          accept;

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        btn_state_next = btn_state_reg;
        accept         = 1'b0;

        case (state_reg)
            IDLE_LOW: begin
                if (s2) begin
                    state_next = WAIT_HIGH;
                    cnt_next   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!s2) begin
                    // Bounce: abandon the candidate without touching outputs.
                    state_next = IDLE_LOW;
                    cnt_next   = '0;
                end else if (cnt_reg == LAST_CNT) begin
                    state_next     = IDLE_HIGH;
                    btn_state_next = 1'b1;
                    accept         = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            IDLE_HIGH: begin
                if (!s2) begin
                    state_next = WAIT_LOW;
                    cnt_next   = '0;
                end
            end
            WAIT_LOW: begin
                if (s2) begin
                    state_next = IDLE_HIGH;
                    cnt_next   = '0;
                end else if (cnt_reg == LAST_CNT) begin
                    state_next     = IDLE_LOW;
                    btn_state_next = 1'b0;
                    accept         = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            default: begin
                state_next = IDLE_LOW;
                cnt_next   = '0;
            end
        endcase

        // Acceptance leads straight into an IDLE state, so two pulses can
        // never be produced on consecutive cycles.
        t_next    = accept && en &&
                    ((btn_state_next && PULSE_RISE) || (!btn_state_next && PULSE_FALL));
        busy_next = (state_next == WAIT_HIGH) || (state_next == WAIT_LOW);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE_LOW;
            cnt_reg       <= '0;
            btn_state_reg <= 1'b0;
            busy_reg      <= 1'b0;
            t_reg         <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            btn_state_reg <= btn_state_next;
            busy_reg      <= busy_next;
            t_reg         <= t_next;
        end
    end

    assign t         = t_reg;
    assign btn_state = btn_state_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_count_enable_debouncer.sv
module tb_count_enable_debouncer;

    logic clk = 1'b0;
    logic rst;
    logic btn_in;
    logic en;
    logic [3:0] t_w;
    logic [3:0] bs_w;
    logic [3:0] busy_w;

    always #5 clk = ~clk;

    // Instances 0..2: STABLE_CYCLES=4 with EDGE 0,1,2. Instance 3: STABLE_CYCLES=1, EDGE=2.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_dut
            count_enable_debouncer #(
                .CW(4),
                .STABLE_CYCLES((gi == 3) ? 1 : 4),
                .EDGE((gi == 0) ? 0 : ((gi == 1) ? 1 : 2))
            ) dut (
                .clk(clk),
                .rst(rst),
                .btn_in(btn_in),
                .en(en),
                .t(t_w[gi]),
                .btn_state(bs_w[gi]),
                .busy(busy_w[gi])
            );
        end
    endgenerate

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int stb(input int i);
        return (i == 3) ? 1 : 4;
    endfunction

    function automatic int edg(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 1 : 2);
    endfunction

    // Behavioural model: a new level is accepted once the synchronised line
    // has disagreed with the current level for STABLE_CYCLES+1 consecutive
    // sampling edges; busy means a disagreement run is in progress.
    logic m_s1 = 1'b0, m_s2 = 1'b0;
    int   run [4];
    logic lvl [4];
    logic mt  [4];
    int   m_pulses0 = 0;

    initial begin
        for (int i = 0; i < 4; i++) begin
            run[i] = 0; lvl[i] = 1'b0; mt[i] = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            m_s1 = 1'b0; m_s2 = 1'b0;
            for (int i = 0; i < 4; i++) begin
                run[i] = 0; lvl[i] = 1'b0; mt[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                mt[i] = 1'b0;
                if (m_s2 != lvl[i]) begin
                    run[i] = run[i] + 1;
                    if (run[i] == stb(i) + 1) begin
                        lvl[i] = m_s2;
                        run[i] = 0;
                        if (en && ((lvl[i] && edg(i) != 1) || (!lvl[i] && edg(i) != 0)))
                            mt[i] = 1'b1;
                    end
                end else begin
                    run[i] = 0;
                end
            end
            if (mt[0]) m_pulses0++;
            m_s2 = m_s1;
            m_s1 = btn_in;
        end
    end

    // Downstream 8-bit counter driven by instance 0's toggle enable.
    logic [7:0] q = 8'd0;
    always @(posedge clk) if (t_w[0]) q <= q + 8'd1;

    logic chk_on = 1'b0;
    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("t[%0d]", i), int'(t_w[i]), int'(mt[i]));
                check($sformatf("btn_state[%0d]", i), int'(bs_w[i]), int'(lvl[i]));
                check($sformatf("busy[%0d]", i), int'(busy_w[i]), int'(run[i] > 0));
            end
        end
    end

    task automatic step(input logic b, input logic e, input logic r);
        btn_in = b; en = e; rst = r;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    int pulses;
    logic [7:0] q0;

    initial begin
        btn_in = 1'b0; en = 1'b1; rst = 1'b1;
        // Scenario 1: reset for two cycles
        step(0, 1, 1);
        chk_on = 1'b1;
        step(0, 1, 1);
        check("rst_t", int'(t_w[0]), 0);
        check("rst_bs", int'(bs_w[0]), 0);
        check("rst_busy", int'(busy_w[0]), 0);
        repeat (3) step(0, 1, 0);
        $display("scenario reset done: t=%0b bs=%0b busy=%0b", t_w[0], bs_w[0], busy_w[0]);

        // Scenario 2: clean press, loop index = edge number
        q0 = q;
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 0);
            if (i == 1) check("press_busy_e1", int'(busy_w[0]), 0);
            if (i == 2) check("press_busy_e2", int'(busy_w[0]), 1);
            if (i == 3) check("s1_t_e3", int'(t_w[3]), 1);
            if (i == 5) check("press_t_e5", int'(t_w[0]), 0);
            if (i == 5) check("press_bs_e5", int'(bs_w[0]), 0);
            if (i == 6) begin
                check("press_t_e6", int'(t_w[0]), 1);
                check("press_bs_e6", int'(bs_w[0]), 1);
                check("press_busy_e6", int'(busy_w[0]), 0);
            end
            if (i == 7) check("press_t_e7", int'(t_w[0]), 0);
        end
        check("press_q_inc", int'(q), int'(q0) + 1);
        $display("scenario clean press done: q=%0d", q);

        // Scenario 4: release held
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 0);
            if (i == 6) begin
                check("rel_t_edge0", int'(t_w[0]), 0);
                check("rel_t_edge1", int'(t_w[1]), 1);
                check("rel_t_edge2", int'(t_w[2]), 1);
                check("rel_bs", int'(bs_w[0]), 0);
            end
        end
        $display("scenario release done: bs=%0b", bs_w[0]);

        // Scenario 3: bouncy press
        pulses = 0;
        step(1, 1, 0); step(0, 1, 0); step(1, 1, 0); step(0, 1, 0);
        check("bounce_bs_hold", int'(bs_w[0]), 0);
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 0);
            if (t_w[0]) pulses++;
        end
        check("bounce_pulses", pulses, 1);
        check("bounce_bs", int'(bs_w[0]), 1);
        repeat (10) step(0, 1, 0);
        $display("scenario bouncy press done: pulses=%0d", pulses);

        // Bounce at the final count cycle rejects the transition
        repeat (4) step(1, 1, 0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 0);
            if (t_w[0]) pulses++;
        end
        check("lastcnt_bs", int'(bs_w[0]), 0);
        check("lastcnt_pulses", pulses, 0);
        repeat (4) step(0, 1, 0);
        $display("scenario final-count bounce done: bs=%0b", bs_w[0]);

        // Scenario 5: en low only at the acceptance edge (also toggled mid-wait)
        for (int i = 0; i < 10; i++) begin
            step(1, (i == 4 || i == 6) ? 1'b0 : 1'b1, 0);
            if (i == 6) begin
                check("supp_t", int'(t_w[0]), 0);
                check("supp_bs", int'(bs_w[0]), 1);
            end
        end
        repeat (10) step(0, 1, 0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 0);
            if (t_w[0]) pulses++;
        end
        check("supp_after_pulses", pulses, 1);
        repeat (10) step(0, 1, 0);
        $display("scenario suppression done: pulses=%0d", pulses);

        // Scenario 6: reset during WAIT_HIGH at cnt=2, line held high
        q0 = q;
        for (int i = 0; i < 16; i++) begin
            step(1, 1, (i == 5) ? 1'b1 : 1'b0);
            if (i == 4) check("rmid_busy_pre", int'(busy_w[0]), 1);
            if (i == 5) begin
                check("rmid_t", int'(t_w[0]), 0);
                check("rmid_bs", int'(bs_w[0]), 0);
                check("rmid_busy", int'(busy_w[0]), 0);
            end
            if (i == 11) check("rmid_t_e11", int'(t_w[0]), 0);
            if (i == 12) check("rmid_t_e12", int'(t_w[0]), 1);
        end
        check("rmid_q_inc", int'(q), int'(q0) + 1);
        repeat (10) step(0, 1, 0);
        check("q_vs_model", int'(q), m_pulses0 & 255);
        $display("scenario reset mid-qualification done: q=%0d", q);

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/count_enable_debouncer.md
Name: count_enable_debouncer

Overview:
- Upstream conditioning stage for the T-flip-flop ripple counter chain.
- Takes a raw, bouncing, asynchronous push-button or sensor line and synchronises it to clk.
- Debounces it with a stability counter and FSM, then emits a clean single-cycle toggle-enable pulse `t` that drives the counter's `t` input.
- Also exports the debounced level and a busy flag for status or LED use.

Parameters:
- CW, default 16: width of the internal stability counter.
- STABLE_CYCLES, default 50000: consecutive clk cycles the synchronised input must hold a new level before it is accepted. Legal range is 1 to 2^CW-1; an out-of-range value is a configuration error.
- EDGE, default 0: which accepted transitions pulse `t`. 0 = rising only, 1 = falling only, 2 = both.

Ports:
- clk, input, 1: system clock, rising-edge active.
- rst, input, 1: synchronous, active-high reset.
- btn_in, input, 1: raw asynchronous input, may bounce.
- en, input, 1: pulse enable. When 0, `t` is suppressed; debouncing continues.
- t, output, 1: one-cycle toggle-enable pulse to the counter.
- btn_state, output, 1: debounced level.
- busy, output, 1: high while a candidate transition is being qualified.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - Both synchroniser flops go to 0; the stability counter goes to 0; the FSM goes to IDLE_LOW.
  - Outputs: t=0, btn_state=0, busy=0.
  - Reset takes priority over all other activity, including mid-qualification.
- Synchroniser: two flops in series, s1 <= btn_in and s2 <= s1. Only s2 is used downstream.
- FSM states: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW.
  - IDLE_LOW: if s2=1, go to WAIT_HIGH with cnt=0. Otherwise stay.
  - WAIT_HIGH:
    - If s2=0, return to IDLE_LOW with cnt=0. This is a bounce, and no output changes.
    - Else if cnt==STABLE_CYCLES-1, go to IDLE_HIGH with btn_state=1.
    - Else cnt increments by 1.
  - IDLE_HIGH and WAIT_LOW mirror the above with the levels inverted. Acceptance clears btn_state to 0.
- busy=1 exactly while in WAIT_HIGH or WAIT_LOW. It is registered.
- t (registered, exactly 1 cycle wide):
  - Asserted in the cycle after the edge that accepts a transition, provided en=1 at that edge and the transition matches EDGE.
  - Never asserted for two consecutive cycles.
- Latency: take edge 0 as the first clk edge that samples btn_in=1 with the input held stable. Then s2=1 after edge 1, WAIT_HIGH is entered at edge 2, and btn_state and t rise at edge 2+STABLE_CYCLES. Total latency is STABLE_CYCLES+2 clocks.
- Boundary conditions:
  - A bounce at the final count cycle (s2 mismatching when cnt==STABLE_CYCLES-1) rejects the transition.
  - STABLE_CYCLES=1 gives latency 3.
  - cnt never exceeds STABLE_CYCLES-1, so no wrap is possible.
  - en is sampled only at the acceptance edge. Toggling en while in a WAIT state has no other effect.
  - If the line is held high through reset, it is re-qualified after reset and produces one rising-edge `t` pulse, because reset defines the prior level as low.
  - A pulse already in flight when rst=1 is cleared at that edge.

Test Plan:
All scenarios use STABLE_CYCLES=4, CW=4, EDGE=0, en=1 unless stated otherwise.
1. Apply rst=1 for 2 cycles with btn_in=X→0, then release → t=0, btn_state=0, busy=0 for all cycles; state remains IDLE_LOW.
2. Clean press: btn_in 0→1 sampled at edge 0 and held → busy=1 from edge 2, btn_state=1 and t=1 after edge 6, t=0 after edge 7, busy=0 after edge 6.
3. Bouncy press: btn_in toggles 1,0,1,0 on successive edges, then holds 1 → no t until 4 stable WAIT cycles elapse; exactly one t pulse; btn_state stays 0 through all bounces.
4. Release with EDGE=0 vs EDGE=2: btn_in 1→0 held → btn_state falls after STABLE_CYCLES+2 cycles. EDGE=0 gives no t; EDGE=2 gives a one-cycle t. Same for the press in the EDGE=1 case, inverted.
5. Suppression: en=0 at the acceptance edge of a press → btn_state=1, t stays 0. Then set en=1 and release/press again → t pulses normally.
6. Reset mid-operation: assert rst during WAIT_HIGH at cnt=2 with btn_in held high → all outputs 0 next cycle; after release, a full re-qualification occurs and t pulses once, STABLE_CYCLES+2 cycles later. Chain into an 8-bit counter and check q increments by exactly 1 per accepted press.
